commit_trace_buffer: RTL
========================

Name: commit_trace_buffer

Overview:
- Receiver for the core's per-instruction commit trace (update, pc, instr, reg_addr, reg_data).
- Accepts one retired-instruction record per cycle and tags it with a sequence number.
- Buffers records in a FIFO and presents them on a valid/ready stream to the bench logger or a slower host link.
- Stops capturing after ECALL/EBREAK retires and flags when the buffer has drained.

Parameters:
- XLEN, 32, data/address width of trace fields.
- DEPTH, 16, FIFO entries; power of two, at least 2.
- SEQ_W, 16, sequence-number width.
- STOP_ON_ENV, 1, when 1, capture stops after an ECALL/EBREAK record is accepted.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- clear_i  in  1  synchronous flush: empties FIFO, zeroes counters and seq, returns to CAPTURE.
- update_i  in  1  a record is valid this cycle (one retired instruction).
- pc_i  in  XLEN  pc of the retired instruction.
- instr_i  in  XLEN  instruction word.
- reg_addr_i  in  5  destination register; 0 means no write.
- reg_data_i  in  XLEN  write-back data.
- m_valid_o  out  1  head record available.
- m_ready_i  in  1  consumer accepts the head record.
- m_pc_o  out  XLEN  head pc.
- m_instr_o  out  XLEN  head instruction.
- m_reg_addr_o  out  5  head destination register.
- m_reg_data_o  out  XLEN  head write-back data.
- m_seq_o  out  SEQ_W  head sequence number.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- full_o  out  1  count_o == DEPTH.
- overflow_o  out  1  sticky: at least one record was dropped.
- drop_cnt_o  out  SEQ_W  number of dropped records; saturates at all-ones.
- stopped_o  out  1  FSM is in STOPPED.
- done_o  out  1  stopped_o and FIFO empty.

Behaviour:
- Reset (rst_i high, asynchronous) drives all outputs to 0: FIFO empty, m_valid_o 0, m_* 0, counters 0, seq 0, FSM in CAPTURE.
- FSM states:
  - CAPTURE: records are accepted.
  - STOPPED: update_i is ignored; it does not advance seq, drop a record or count a drop.
  - CAPTURE to STOPPED: on the clock edge that accepts a record with instr_i == 32'h0000_0073 or 32'h0010_0073, when STOP_ON_ENV=1. That record is stored.
  - STOPPED to CAPTURE: only via clear_i or reset.
- Acceptance, in CAPTURE:
  - With update_i=1, the record is written if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Simultaneous push and pop at full is legal and leaves count unchanged.
  - Otherwise the record is dropped: overflow_o is set and drop_cnt_o increments, saturating.
- Sequence:
  - seq increments by 1 on every update_i=1 in CAPTURE, whether the record is stored or dropped, so gaps in m_seq_o reveal drops.
  - The stored tag is the seq value before the increment; the first record is tagged 0.
  - seq wraps modulo 2^SEQ_W.
- Output stream:
  - First-word fall-through: m_valid_o = !empty, and m_* shows the head entry.
  - A record written at edge N is visible after edge N, giving 1-cycle latency from update_i to m_valid_o.
  - A pop occurs when m_valid_o && m_ready_i.
  - m_* stays stable while m_valid_o=1 and m_ready_i=0.
  - When empty, m_* holds its last value; the consumer must not sample it.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is tracked by count_o, and push/pop in the same cycle leaves it unchanged.
- count_o / full_o: registered and consistent with the FIFO state after each edge.
- clear_i priority:
  - clear_i has priority over push and pop in the same cycle. The record present that cycle is discarded and is not counted as a drop.
  - After the edge: count 0, seq 0, drop_cnt 0, overflow 0, FSM in CAPTURE.
- Reset mid-operation: asserting rst_i asynchronously empties the FIFO at any time, and m_valid_o falls without waiting for a clock.
- reg_addr_i=0 records are stored unchanged; no filtering.
- done_o: combinational from stopped_o and empty.

Test Plan:
- Basic flow: reset, then 3 updates with pc 0x8000_0000/04/08 and m_ready_i=1 → m_valid_o 1 cycle later per record, m_seq_o 0,1,2 in order, count_o returns to 0.
- Backpressure and overflow: DEPTH=16, m_ready_i=0, 20 consecutive updates → full_o after 16, overflow_o=1, drop_cnt_o=4. Then drain with ready=1 → seq 0..15, 16 pops, count 0.
- Push and pop at full: fill to 16, then update_i=1 with m_ready_i=1 → count stays 16, no drop, new entry tagged 16.
- Env stop: records addi, addi, ecall (0x00000073), then an addi → stopped_o=1 after the ecall edge, the final addi is ignored and seq stays 3. After draining, done_o=1.
- Clear: 5 records stored plus overflow set, then clear_i=1 with update_i=1 in the same cycle → count 0, overflow 0, drop_cnt 0. The next record is tagged seq 0.
- Async reset: assert rst_i between clock edges with 4 entries buffered → m_valid_o and count_o go to 0 immediately, and stopped_o=0.

Source files
------------

// File: rtl/commit_trace_buffer.sv
// -----------------------------------------------------------------------------
// commit_trace_buffer
//
// Receives the core's per-instruction commit trace, tags each retired record
// with a sequence number and buffers it in a first-word-fall-through FIFO.
// The FIFO drains onto a valid/ready stream towards a logger or slow host link.
// Capture stops once an ECALL/EBREAK record has been stored (STOP_ON_ENV=1).
// done_o flags that the buffer has drained after the stop.
//
// Stream handshake: a record transfers on every rising clk_i edge where
// m_valid_o && m_ready_i. m_valid_o never depends on m_ready_i. While
// m_valid_o=1 and m_ready_i=0 the m_* fields stay stable. While
// m_valid_o=0 the m_* fields hold the last value shown and carry no meaning.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   clear_i             synchronous flush (FIFO, counters, seq, FSM)
//   update_i            one retired-instruction record this cycle
//   pc_i, instr_i       pc and instruction word of the record
//   reg_addr_i          destination register (0 = no write, stored as is)
//   reg_data_i          write-back data
//   m_valid_o/m_ready_i output stream handshake
//   m_pc_o .. m_seq_o   head record fields and its sequence tag
//   count_o, full_o     registered occupancy and full flag
//   overflow_o          sticky: a record was dropped
//   drop_cnt_o          saturating count of dropped records
//   stopped_o           capture FSM is in STOPPED
//   done_o              stopped and FIFO empty
// -----------------------------------------------------------------------------
module commit_trace_buffer #(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 16,
   parameter int SEQ_W       = 16,
   parameter int STOP_ON_ENV = 1
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clear_i,
   input  logic                     update_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          instr_i,
   input  logic [4:0]               reg_addr_i,
   input  logic [XLEN-1:0]          reg_data_i,
   output logic                     m_valid_o,
   input  logic                     m_ready_i,
   output logic [XLEN-1:0]          m_pc_o,
   output logic [XLEN-1:0]          m_instr_o,
   output logic [4:0]               m_reg_addr_o,
   output logic [XLEN-1:0]          m_reg_data_o,
   output logic [SEQ_W-1:0]         m_seq_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     overflow_o,
   output logic [SEQ_W-1:0]         drop_cnt_o,
   output logic                     stopped_o,
   output logic                     done_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   localparam logic [XLEN-1:0] ECALL_WORD  = XLEN'(32'h0000_0073);
   localparam logic [XLEN-1:0] EBREAK_WORD = XLEN'(32'h0010_0073);

   typedef enum logic {
      ST_CAPTURE = 1'b0,
      ST_STOPPED = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // FIFO storage (no reset needed: never read while empty)
   logic [XLEN-1:0]  r_pc_mem    [DEPTH];
   logic [XLEN-1:0]  r_instr_mem [DEPTH];
   logic [4:0]       r_ra_mem    [DEPTH];
   logic [XLEN-1:0]  r_rd_mem    [DEPTH];
   logic [SEQ_W-1:0] r_seq_mem   [DEPTH];

   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic [SEQ_W-1:0] r_seq;
   logic [SEQ_W-1:0] r_drop_cnt;
   logic             r_overflow;

   // Copy of the last head shown; drives m_* while the FIFO is empty so the
   // outputs hold their last value instead of exposing a stale slot.
   logic [XLEN-1:0]  r_last_pc;
   logic [XLEN-1:0]  r_last_instr;
   logic [4:0]       r_last_ra;
   logic [XLEN-1:0]  r_last_rd;
   logic [SEQ_W-1:0] r_last_seq;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_capture;
   logic w_push;
   logic w_drop;
   logic w_is_env;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CW'(DEPTH));
   assign w_pop    = !w_empty && m_ready_i && !clear_i;
   assign w_capture = update_i && (r_state == ST_CAPTURE) && !clear_i;
   // At full, a same-cycle pop frees the slot being written.
   assign w_push   = w_capture && (!w_full || w_pop);
   assign w_drop   = w_capture && !w_push;
   assign w_is_env = (instr_i == ECALL_WORD) || (instr_i == EBREAK_WORD);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_CAPTURE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (clear_i) begin
         w_state_next = ST_CAPTURE;
      end else if ((r_state == ST_CAPTURE) && w_push && w_is_env && (STOP_ON_ENV != 0)) begin
         w_state_next = ST_STOPPED;
      end
   end

   // ---------------------------------------------------------------- storage
   always_ff @(posedge clk_i) begin
      if (w_push) begin
         r_pc_mem[r_wr_ptr]    <= pc_i;
         r_instr_mem[r_wr_ptr] <= instr_i;
         r_ra_mem[r_wr_ptr]    <= reg_addr_i;
         r_rd_mem[r_wr_ptr]    <= reg_data_i;
         r_seq_mem[r_wr_ptr]   <= r_seq;
      end
   end

   // ---------------------------------------------------------------- control
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_seq      <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end else if (clear_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_seq      <= '0;
         r_drop_cnt <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CW'(1);
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CW'(1);
         end
         // Every captured update consumes a tag, stored or not.
         if (w_capture) begin
            r_seq <= r_seq + SEQ_W'(1);
         end
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != '1) begin
               r_drop_cnt <= r_drop_cnt + SEQ_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_last_pc    <= '0;
         r_last_instr <= '0;
         r_last_ra    <= '0;
         r_last_rd    <= '0;
         r_last_seq   <= '0;
      end else if (!w_empty) begin
         r_last_pc    <= r_pc_mem[r_rd_ptr];
         r_last_instr <= r_instr_mem[r_rd_ptr];
         r_last_ra    <= r_ra_mem[r_rd_ptr];
         r_last_rd    <= r_rd_mem[r_rd_ptr];
         r_last_seq   <= r_seq_mem[r_rd_ptr];
      end
   end

   // ---------------------------------------------------------------- outputs
   assign m_valid_o    = !w_empty;
   assign m_pc_o       = w_empty ? r_last_pc    : r_pc_mem[r_rd_ptr];
   assign m_instr_o    = w_empty ? r_last_instr : r_instr_mem[r_rd_ptr];
   assign m_reg_addr_o = w_empty ? r_last_ra    : r_ra_mem[r_rd_ptr];
   assign m_reg_data_o = w_empty ? r_last_rd    : r_rd_mem[r_rd_ptr];
   assign m_seq_o      = w_empty ? r_last_seq   : r_seq_mem[r_rd_ptr];
   assign count_o      = r_count;
   assign full_o       = w_full;
   assign overflow_o   = r_overflow;
   assign drop_cnt_o   = r_drop_cnt;
   assign stopped_o    = (r_state == ST_STOPPED);
   assign done_o       = stopped_o && w_empty;

endmodule
